// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one combinational ALU between two requesters
// Optional feature macro: COPPERV_ALU_ARB_RR_EN (round-robin tie breaking;
// when undefined, req0 has fixed priority and no last_grant state exists).
module alu_share_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ALU_OP_WIDTH   = 4,
    parameter int unsigned ALU_COMP_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [DATA_WIDTH-1:0]     req0_din1,
    input  logic [DATA_WIDTH-1:0]     req0_din2,
    input  logic [ALU_OP_WIDTH-1:0]   req0_op,

    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [DATA_WIDTH-1:0]     req1_din1,
    input  logic [DATA_WIDTH-1:0]     req1_din2,
    input  logic [ALU_OP_WIDTH-1:0]   req1_op,

    output logic                      rsp0_valid,
    input  logic                      rsp0_ready,
    output logic [DATA_WIDTH-1:0]     rsp0_dout,
    output logic [ALU_COMP_WIDTH-1:0] rsp0_comp,

    output logic                      rsp1_valid,
    input  logic                      rsp1_ready,
    output logic [DATA_WIDTH-1:0]     rsp1_dout,
    output logic [ALU_COMP_WIDTH-1:0] rsp1_comp,

    output logic [DATA_WIDTH-1:0]     alu_din1,
    output logic [DATA_WIDTH-1:0]     alu_din2,
    output logic [ALU_OP_WIDTH-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0]     alu_dout,
    input  logic [ALU_COMP_WIDTH-1:0] alu_comp
);

    // Encoding of the core's no-operation opcode.
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NOP = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_next;

    logic                      owner;
    logic [DATA_WIDTH-1:0]     issue_din1;
    logic [DATA_WIDTH-1:0]     issue_din2;
    logic [ALU_OP_WIDTH-1:0]   issue_op;

    logic                      owner_hs;
    logic                      accept_window;
    logic                      any_valid;
    logic                      winner;
    logic                      grant;

`ifdef COPPERV_ALU_ARB_RR_EN
    logic                      last_grant;
`endif

    // Accept window, winner selection and the combinational ready strobes.
    always_comb begin
        owner_hs      = 1'b0;
        accept_window = 1'b0;
        any_valid     = 1'b0;
        winner        = 1'b0;
        grant         = 1'b0;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;

        owner_hs = owner ? (rsp1_valid & rsp1_ready) : (rsp0_valid & rsp0_ready);

        // No grant is ever offered while reset is asserted.
        accept_window = rst & ((state == S_IDLE) | ((state == S_HOLD) & owner_hs));

        any_valid = req0_valid | req1_valid;

        if (req0_valid && req1_valid) begin
`ifdef COPPERV_ALU_ARB_RR_EN
            winner = ~last_grant;
`else
            winner = 1'b0;
`endif
        end else begin
            winner = req1_valid;
        end

        grant      = accept_window & any_valid;
        req0_ready = grant & ~winner;
        req1_ready = grant & winner;
    end

    // Next-state logic for the IDLE -> EXEC -> HOLD sequence.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (grant) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                state_next = S_HOLD;
            end
            S_HOLD: begin
                if (owner_hs) begin
                    state_next = grant ? S_EXEC : S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Issue registers and ownership are loaded only on an accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= 1'b0;
            issue_din1 <= '0;
            issue_din2 <= '0;
            issue_op   <= '0;
        end else if (grant) begin
            owner      <= winner;
            issue_din1 <= winner ? req1_din1 : req0_din1;
            issue_din2 <= winner ? req1_din2 : req0_din2;
            issue_op   <= winner ? req1_op   : req0_op;
        end
    end

`ifdef COPPERV_ALU_ARB_RR_EN
    // Remember the latest winner; reset value lets req0 win the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if (grant) begin
            last_grant <= winner;
        end
    end
`endif

    // Response registers: capture the ALU at the end of EXEC, release on handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp0_valid <= 1'b0;
            rsp0_dout  <= '0;
            rsp0_comp  <= '0;
            rsp1_valid <= 1'b0;
            rsp1_dout  <= '0;
            rsp1_comp  <= '0;
        end else if (state == S_EXEC) begin
            if (owner) begin
                rsp1_valid <= 1'b1;
                rsp1_dout  <= alu_dout;
                rsp1_comp  <= alu_comp;
            end else begin
                rsp0_valid <= 1'b1;
                rsp0_dout  <= alu_dout;
                rsp0_comp  <= alu_comp;
            end
        end else if ((state == S_HOLD) && owner_hs) begin
            if (owner) begin
                rsp1_valid <= 1'b0;
            end else begin
                rsp0_valid <= 1'b0;
            end
        end
    end

    // Operands always reflect the issue registers; the opcode is live only in EXEC.
    assign alu_din1 = issue_din1;
    assign alu_din2 = issue_din2;
    assign alu_op   = (state == S_EXEC) ? issue_op : ALU_OP_NOP;

endmodule
